// File: rtl/ad7476_spi_reader_pkg.sv
// Shared definitions for the AD7476 serial reader: FSM encoding and frame geometry.
package ad7476_spi_reader_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int DATA_BITS      = 12;
  localparam int LEAD_ZERO_BITS = 4;
  localparam int BIT_CNT_W      = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SCK_LOW,
    ST_SCK_HIGH,
    ST_QUIET
  } state_t;

  // The converter always sends leading zeros; anything else means a corrupted frame.
  function automatic logic lead_bits_set(input logic [FRAME_BITS-1:0] frame);
    return |frame[FRAME_BITS-1 -: LEAD_ZERO_BITS];
  endfunction

endpackage

// File: rtl/ad7476_spi_reader.sv
// Reads one 16-bit AD7476 frame per request (or back to back in continuous mode)
// and presents the 12-bit sample with a leading-zero error flag.
module ad7476_spi_reader
  import ad7476_spi_reader_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int QUIET_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        cont_i,
  output logic        spi_ss_o,
  output logic        spi_sck_o,
  input  logic        spi_miso_i,
  output logic [11:0] data_o,
  output logic        data_valid_o,
  output logic        frame_err_o,
  output logic        busy_o,
  output logic        missed_start_o
);

  localparam logic [7:0]           DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]           QUIET_LAST = 8'(QUIET_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_BITS - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic                   ss_d, sck_d, valid_d, err_d, busy_d, missed_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   cnt_done, last_quiet;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      spi_ss_o       <= 1'b1;
      spi_sck_o      <= 1'b1;
      data_o         <= '0;
      data_valid_o   <= 1'b0;
      frame_err_o    <= 1'b0;
      busy_o         <= 1'b0;
      missed_start_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      spi_ss_o       <= ss_d;
      spi_sck_o      <= sck_d;
      data_o         <= data_d;
      data_valid_o   <= valid_d;
      frame_err_o    <= err_d;
      busy_o         <= busy_d;
      missed_start_o <= missed_d;
    end
  end

  // One counter serves as the SCK half-period divider and the quiet-time timer.
  assign cnt_done   = (cnt_q == DIV_LAST);
  assign last_quiet = (state_q == ST_QUIET) && (cnt_q == QUIET_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ss_d     = spi_ss_o;
    sck_d    = spi_sck_o;
    data_d   = data_o;
    err_d    = frame_err_o;
    valid_d  = 1'b0;
    missed_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i || cont_i) begin
          state_d = ST_CS_SETUP;
          ss_d    = 1'b0;
          sck_d   = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end
      end

      ST_CS_SETUP: begin
        if (cnt_done) begin
          shift_d = {shift_q[FRAME_BITS-2:0], spi_miso_i};
          sck_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SCK_LOW;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SCK_LOW: begin
        if (cnt_done) begin
          sck_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_SCK_HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SCK_HIGH: begin
        if (cnt_done) begin
          cnt_d = '0;
          // Sample before SCK falls so the ADC has not yet shifted the next bit out.
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BIT_CNT_W'(1);
            shift_d = {shift_q[FRAME_BITS-2:0], spi_miso_i};
            sck_d   = 1'b0;
            state_d = ST_SCK_LOW;
          end else begin
            ss_d    = 1'b1;
            data_d  = shift_q[DATA_BITS-1:0];
            err_d   = lead_bits_set(shift_q);
            valid_d = 1'b1;
            state_d = ST_QUIET;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_QUIET: begin
        if (last_quiet) begin
          cnt_d = '0;
          if (cont_i || start_i) begin
            state_d = ST_CS_SETUP;
            ss_d    = 1'b0;
            sck_d   = 1'b1;
            bit_d   = '0;
            shift_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ss_d    = 1'b1;
        sck_d   = 1'b1;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    if ((state_q != ST_IDLE) && start_i && !last_quiet)
      missed_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: doc/ad7476_spi_reader.md
AD7476_SPI_READER -- requirements
Module: ad7476_spi_reader

Interface
REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk_i cycles; legal range 2..255.
REQ-002 Parameter QUIET_CYCLES, default 4: minimum spi_ss_o high time between frames, in clk_i cycles; legal range 1..255.
REQ-003 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  one-cycle request to read one conversion.
REQ-006 cont_i  input  1  continuous mode: when high, a new frame starts automatically after each quiet period.
REQ-007 spi_ss_o  output  1  active-low chip select to the ADC.
REQ-008 spi_sck_o  output  1  serial clock to the ADC; idles high.
REQ-009 spi_miso_i  input  1  serial data from the ADC, MSB first.
REQ-010 data_o  output  12  last received sample, equal to frame bits [11:0].
REQ-011 data_valid_o  output  1  one-cycle pulse when data_o updates.
REQ-012 frame_err_o  output  1  qualified by data_valid_o; high when frame bits [15:12] are not 4'h0.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 missed_start_o  output  1  one-cycle pulse when start_i is ignored.

Function
REQ-015 The FSM shall have the states IDLE, CS_SETUP, SCK_LOW, SCK_HIGH and QUIET, with all outputs registered.
REQ-016 IDLE transitions:
- start_i=1 or cont_i=1 -> CS_SETUP.
- Next cycle: spi_ss_o=0 and spi_sck_o=1.
REQ-017 CS_SETUP shall last CLK_DIV cycles, then:
- sample spi_miso_i into frame bit 15;
- drive spi_sck_o low;
- go to SCK_LOW.
REQ-018 SCK_LOW shall last CLK_DIV cycles, then drive spi_sck_o high and go to SCK_HIGH.
REQ-019 SCK_HIGH shall last CLK_DIV cycles, then:
- if fewer than 16 bits have been sampled: sample the next bit (15 down to 0), drive spi_sck_o low, go to SCK_LOW;
- otherwise: drive spi_ss_o high, go to QUIET.
REQ-020 Frame timing:
- Each bit is sampled in the same cycle that spi_sck_o is driven low, i.e. before the ADC shifts on the falling edge.
- Exactly 16 falling SCK edges per frame.
- spi_ss_o low for exactly 33*CLK_DIV cycles.
REQ-021 Output update at frame end:
- data_o, frame_err_o and data_valid_o=1 are updated in the same cycle spi_ss_o returns high.
- data_o holds its value until the next valid frame.
REQ-022 spi_miso_i shall be sampled directly with no synchronizer, because SCK is derived from clk_i.
REQ-023 QUIET shall last QUIET_CYCLES cycles, then:
- go to CS_SETUP if cont_i=1;
- go to CS_SETUP if start_i is asserted in the last QUIET cycle;
- otherwise go to IDLE.
REQ-024 start_i=1 while busy_o=1 shall be ignored and pulse missed_start_o, except in the last QUIET cycle; the frame in progress is unaffected.
REQ-025 The half-period divider shall count from 0 to CLK_DIV-1; the bit counter shall count from 0 to 15; neither counter wraps mid-frame.
REQ-026 Deasserting cont_i mid-frame shall complete the current frame and its quiet period, then return to IDLE.

Reset
REQ-027 Asserting rst_i shall immediately set the following, including mid-frame:
- state IDLE;
- spi_ss_o=1, spi_sck_o=1;
- data_o=12'h000;
- data_valid_o=0, frame_err_o=0, busy_o=0, missed_start_o=0;
- counters and shift register to 0.
REQ-028 A frame interrupted by reset shall produce no data_valid_o pulse.
REQ-029 The first start_i after reset deassertion shall be accepted on the first clk_i edge.

Structure
REQ-030 A shared package shall hold the state encoding and the constants FRAME_BITS=16, DATA_BITS=12 and LEAD_ZERO_BITS=4.
REQ-031 The block shall be a single module with the divider, bit counter and shift register inline; no sub-module.

Verification
Benches use CLK_DIV=2 and QUIET_CYCLES=4 with a behavioural ADC model: it loads a 16-bit word while SS is high, drives the MSB when SS falls, and shifts on SCK negedge.
REQ-032 Model word 16'h0ABC, single start_i -> one data_valid_o pulse with data_o=12'hABC and frame_err_o=0; SS low exactly 66 cycles; 16 SCK falling edges.
REQ-033 Model word 16'h5FFF -> data_o=12'hFFF and frame_err_o=1.
REQ-034 start_i pulsed at bit 7 of a frame -> missed_start_o pulses once; data_o matches the original frame; returns to IDLE after QUIET.
REQ-035 rst_i asserted mid-frame (bit 9) -> spi_ss_o=1, spi_sck_o=1 and busy_o=0 immediately; no data_valid_o; a subsequent start_i produces a correct frame.
REQ-036 cont_i=1 with the model counting 0,1,2,... -> data_o sequence 0x000, 0x001, 0x002; SS high exactly 4 cycles between frames; deasserting cont_i stops the sequence after the current frame.
REQ-037 start_i held high in the last QUIET cycle -> next frame begins with no IDLE cycle and no missed_start_o pulse.
